// File: rtl/display_saida.sv
// display_saida: captures a 4-bit result and overflow flag from the calculator
// controller, splits the value into decimal tens/ones digits and drives a
// 2-digit multiplexed, active-low 7-segment display. An overflowed result blinks.
module display_saida #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  output logic       ready,
  input  logic       clear,
  input  logic [3:0] Z,
  input  logic       overflow,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {BLANK, CONV, SHOW} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      val_reg;
  logic            ovf_reg;
  logic            tens_reg;
  logic [3:0]      ones_reg;
  logic [SW-1:0]   scan_cnt_reg;
  logic            sel_reg;
  logic [BW-1:0]   blink_cnt_reg;
  logic            blink_on_reg;
  logic [6:0]      seg_reg, seg_next;
  logic [1:0]      an_reg, an_next;
  logic            capture;

  // Digit 0..9 to active-low segment pattern (a..g on bits 6..0)
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h01;
      4'd1:    seg_pattern = 7'h4F;
      4'd2:    seg_pattern = 7'h12;
      4'd3:    seg_pattern = 7'h06;
      4'd4:    seg_pattern = 7'h4C;
      4'd5:    seg_pattern = 7'h24;
      4'd6:    seg_pattern = 7'h20;
      4'd7:    seg_pattern = 7'h0F;
      4'd8:    seg_pattern = 7'h00;
      4'd9:    seg_pattern = 7'h04;
      default: seg_pattern = SEG_OFF;
    endcase
  endfunction

  assign ready   = (state_reg != CONV);
  // Clear has priority over a capture offered in the same cycle
  assign capture = valid && ready && !clear;
  assign seg     = seg_reg;
  assign an      = an_reg;

  // Next-state logic: clear always blanks, capture always converts
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = BLANK;
    end else if (capture) begin
      state_next = CONV;
    end else if (state_reg == CONV) begin
      state_next = SHOW;
    end
  end

  // Display drive: held during CONV so the previous digits stay visible
  always_comb begin
    seg_next = seg_reg;
    an_next  = an_reg;
    case (state_reg)
      BLANK: begin
        seg_next = SEG_OFF;
        an_next  = 2'b11;
      end
      SHOW: begin
        if (ovf_reg && !blink_on_reg) begin
          seg_next = SEG_OFF;
          an_next  = 2'b11;
        end else if (!sel_reg) begin
          seg_next = seg_pattern(ones_reg);
          an_next  = 2'b10;
        end else begin
          seg_next = tens_reg ? seg_pattern(4'd1) : SEG_OFF;
          an_next  = 2'b01;
        end
      end
      default: begin
        seg_next = seg_reg;
        an_next  = an_reg;
      end
    endcase
  end

  // State, captured value, digit conversion, scan/blink timers and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= BLANK;
      val_reg       <= 4'd0;
      ovf_reg       <= 1'b0;
      tens_reg      <= 1'b0;
      ones_reg      <= 4'd0;
      scan_cnt_reg  <= '0;
      sel_reg       <= 1'b0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
      seg_reg       <= SEG_OFF;
      an_reg        <= 2'b11;
    end else begin
      state_reg <= state_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;

      if (capture) begin
        val_reg <= Z;
        ovf_reg <= overflow;
      end

      if (state_reg == CONV) begin
        tens_reg <= (val_reg >= 4'd10);
        ones_reg <= (val_reg >= 4'd10) ? (val_reg - 4'd10) : val_reg;
      end

      // Free-running digit scan, independent of captures
      if (scan_cnt_reg == SCAN_LAST) begin
        scan_cnt_reg <= '0;
        sel_reg      <= !sel_reg;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end

      // Blink restarts in the visible phase on every capture
      if (capture) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= !blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_saida.sv
// tb_display_saida: table-driven check of value capture and digit display,
// plus directed sequences for blink, clear priority, busy-ignore and reset.
module tb_display_saida;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       ready;
  logic       clear;
  logic [3:0] Z;
  logic       overflow;
  logic [6:0] seg;
  logic [1:0] an;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] z;
    logic [6:0] ones_seg;
    logic [6:0] tens_seg;
  } vec_t;

  vec_t vecs [7];

  display_saida #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .ready    (ready),
    .clear    (clear),
    .Z        (Z),
    .overflow (overflow),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  task automatic chk_blank(input string name);
    chk({name, " seg"}, 32'(seg), 32'h7F);
    chk({name, " an"},  32'(an),  32'h3);
  endtask

  task automatic chk_slot(input logic [6:0] ones_seg, input logic [6:0] tens_seg,
                          output logic saw_ones, output logic saw_tens);
    saw_ones = 1'b0;
    saw_tens = 1'b0;
    if (an == 2'b10) begin
      saw_ones = 1'b1;
      chk("ones seg", 32'(seg), 32'(ones_seg));
    end else if (an == 2'b01) begin
      saw_tens = 1'b1;
      chk("tens seg", 32'(seg), 32'(tens_seg));
    end else begin
      chk("an slot", 32'(an), 32'h2);
    end
  endtask

  // Samples n cycles, each a valid digit slot; a full scan period must see both
  task automatic chk_show(input logic [6:0] ones_seg, input logic [6:0] tens_seg, input int n);
    logic so, st, any_o, any_t;
    any_o = 1'b0;
    any_t = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk_slot(ones_seg, tens_seg, so, st);
      any_o |= so;
      any_t |= st;
    end
    if (n >= 8) chk("both slots", {30'd0, any_o, any_t}, 32'h3);
  endtask

  // Capture: edge N accepts, ready low one cycle, back high after N+1
  task automatic do_capture(input logic [3:0] z, input logic ovf);
    valid    = 1'b1;
    Z        = z;
    overflow = ovf;
    step();
    chk("ready in conv", 32'(ready), 32'h0);
    valid    = 1'b0;
    overflow = 1'b0;
    step();
    chk("ready in show", 32'(ready), 32'h1);
  endtask

  initial begin
    logic so, st;
    vecs[0] = '{4'd13, 7'h06, 7'h4F};
    vecs[1] = '{4'd5,  7'h24, 7'h7F};
    vecs[2] = '{4'd0,  7'h01, 7'h7F};
    vecs[3] = '{4'd10, 7'h01, 7'h4F};
    vecs[4] = '{4'd15, 7'h24, 7'h4F};
    vecs[5] = '{4'd9,  7'h04, 7'h7F};
    vecs[6] = '{4'd7,  7'h0F, 7'h7F};

    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; Z = 4'd0; overflow = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk_blank("reset");
      chk("reset ready", 32'(ready), 32'h1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_blank("idle blank");
    end

    for (int v = 0; v < 7; v++) begin
      do_capture(vecs[v].z, 1'b0);
      chk_show(vecs[v].ones_seg, vecs[v].tens_seg, 8);
    end

    // Overflow blink: visible edges N+2..N+16, blank N+17..N+32, visible again
    do_capture(4'd9, 1'b1);
    for (int k = 2; k <= 40; k++) begin
      step();
      if (k <= 16 || k >= 33) chk_slot(7'h04, 7'h7F, so, st);
      else chk_blank("blink off");
    end

    // Clear beats valid in the same cycle
    clear = 1'b1; valid = 1'b1; Z = 4'd7;
    step();
    chk("ready after clear", 32'(ready), 32'h1);
    clear = 1'b0; valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_blank("cleared");
    end

    // Valid held into CONV with a new Z is ignored
    valid = 1'b1; Z = 4'd8;
    step();
    chk("ready conv busy", 32'(ready), 32'h0);
    Z = 4'd2;
    step();
    chk("ready after busy", 32'(ready), 32'h1);
    valid = 1'b0;
    chk_show(7'h00, 7'h7F, 8);

    // Reset while showing 13
    do_capture(4'd13, 1'b0);
    chk_show(7'h06, 7'h4F, 4);
    rst_n = 1'b0;
    step();
    chk_blank("reset in show");
    chk("ready reset show", 32'(ready), 32'h1);
    rst_n = 1'b1;

    // Reset during CONV
    valid = 1'b1; Z = 4'd13;
    step();
    chk("ready conv pre-reset", 32'(ready), 32'h0);
    valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk_blank("reset in conv");
    chk("ready reset conv", 32'(ready), 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_blank("post reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
